// File: rtl/tx_rr_scheduler_if.sv
// Requester and transmitter handshake bundle
// for the round-robin UART scheduler.
interface tx_rr_scheduler_if #(
  parameter int FRAME_DATA = 8,
  parameter int NUM_REQ    = 4
);
  localparam int CW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FRAME_DATA-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            sent;
  logic [NUM_REQ-1:0]            abort;
  logic                          tx_en;
  logic [FRAME_DATA-1:0]         tx_data;
  logic                          tx_busy;
  logic                          tx_done;
  logic                          sched_busy;
  logic [CW-1:0]                 cur_id;

  modport slave (
    input  req, req_data, tx_busy, tx_done,
    output grant, sent, abort, tx_en,
    output tx_data, sched_busy, cur_id
  );

  modport master (
    output req, req_data, tx_busy, tx_done,
    input  grant, sent, abort, tx_en,
    input  tx_data, sched_busy, cur_id
  );
endinterface

// File: rtl/tx_rr_scheduler.sv
// Round-robin arbiter sharing one UART transmitter
// between NUM_REQ byte producers, with launch watchdog.
module tx_rr_scheduler #(
  parameter int FRAME_DATA     = 8,
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int LAUNCH_TIMEOUT = 16
) (
  input logic clk,
  input logic tx_rst,
  tx_rr_scheduler_if.slave bus
);
  localparam int CW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(LAUNCH_TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] TMAX = TW'(LAUNCH_TIMEOUT - 1);
  localparam logic [GW-1:0] GMAX =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LASTID = CW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         rr_q;
  logic [CW-1:0]         cur_id_q;
  logic [TW-1:0]         tcnt_q;
  logic [GW-1:0]         gcnt_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    sent_q;
  logic [NUM_REQ-1:0]    abort_q;
  logic                  tx_en_q;
  logic [FRAME_DATA-1:0] tx_data_q;
  logic                  busy_q;

  logic                  pick_vld;
  logic [CW-1:0]         pick_id;
  logic [FRAME_DATA-1:0] pick_data;
  int                    idx;

  // First set request at or above the rr pointer, with wrap;
  // scanning downward lets the nearest candidate win last.
  always_comb begin
    pick_vld  = 1'b0;
    pick_id   = '0;
    pick_data = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (bus.req[idx]) begin
        pick_vld  = 1'b1;
        pick_id   = CW'(idx);
        pick_data = bus.req_data[idx*FRAME_DATA +: FRAME_DATA];
      end
    end
  end

  // Scheduler FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (tx_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      cur_id_q  <= '0;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
      grant_q   <= '0;
      sent_q    <= '0;
      abort_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      grant_q <= '0;
      sent_q  <= '0;
      abort_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q   <= ONE << pick_id;
            tx_data_q <= pick_data;
            cur_id_q  <= pick_id;
            rr_q      <= (pick_id == LASTID) ?
                         '0 : pick_id + CW'(1);
            busy_q    <= 1'b1;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en_q <= 1'b1;
          tcnt_q  <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // done without busy still counts as a frame
          if (bus.tx_done) begin
            tx_en_q <= 1'b0;
            sent_q  <= ONE << cur_id_q;
            gcnt_q  <= '0;
            state_q <= GAP;
          end else if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tcnt_q == TMAX) begin
            tx_en_q <= 1'b0;
            abort_q <= ONE << cur_id_q;
            gcnt_q  <= '0;
            state_q <= GAP;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            tx_en_q <= 1'b0;
            sent_q  <= ONE << cur_id_q;
            gcnt_q  <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gcnt_q == GMAX) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: begin
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sent       = sent_q;
  assign bus.abort      = abort_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.sched_busy = busy_q;
  assign bus.cur_id     = cur_id_q;
endmodule
